// File: rtl/register_pkg.sv
// register_pkg
// Shared types and constants for the register bank read path.
//   rd_state_t : occupancy state of the 2-entry read response buffer
//   RSP_DEPTH  : number of entries in the response buffer
package register_pkg;

    typedef enum logic [1:0] {
        RD_EMPTY = 2'd0,
        RD_ONE   = 2'd1,
        RD_FULL  = 2'd2
    } rd_state_t;

    localparam int RSP_DEPTH = 2;

endpackage

// File: rtl/register_reader_if.sv
// register_reader_if
// Request/response handshake bundle between a register read consumer
// (master) and the register_reader block (slave).
//   req_valid/req_addr/req_ready : read request channel
//   rsp_valid/rsp_data/rsp_error/rsp_ready : read response channel
//   rsp_parity : even parity of rsp_data, only with REGISTER_READER_PARITY_EN
interface register_reader_if #(
    parameter int N     = 3,
    parameter int COUNT = 4
);
    localparam int ADDR_W = $clog2(COUNT);

    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              rsp_valid;
    logic [N-1:0]      rsp_data;
    logic              rsp_error;
    logic              rsp_ready;
`ifdef REGISTER_READER_PARITY_EN
    logic              rsp_parity;
`endif

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_error,
`ifdef REGISTER_READER_PARITY_EN
        input  rsp_parity,
`endif
        output rsp_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        output rsp_error,
`ifdef REGISTER_READER_PARITY_EN
        output rsp_parity,
`endif
        input  rsp_ready
    );

endinterface

// File: rtl/register_reader_buffer.sv
// register_reader_buffer
// Two-entry FIFO holding read responses, with an occupancy FSM.
// Entry 0 is always the head; entry 1 holds the second response when full.
//   clk, reset_n : clock, asynchronous active-low reset
//   push_valid/push_data/push_ready : write side
//   pop_valid/pop_data/pop_ready    : read side (pop_data is the head entry)
module register_reader_buffer
    import register_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push_valid,
    input  logic [W-1:0] push_data,
    output logic         push_ready,
    output logic         pop_valid,
    output logic [W-1:0] pop_data,
    input  logic         pop_ready
);

    rd_state_t    state_r;
    rd_state_t    state_s;
    logic [W-1:0] mem_r [RSP_DEPTH];
    logic [W-1:0] mem_s [RSP_DEPTH];
    logic         push_s;
    logic         pop_s;

    // Handshake flags decode from registered state only, so no
    // combinational path runs from pop_ready to push_ready.
    assign push_ready = (state_r != RD_FULL);
    assign pop_valid  = (state_r != RD_EMPTY);
    assign pop_data   = mem_r[0];
    assign push_s     = push_valid && push_ready;
    assign pop_s      = pop_valid && pop_ready;

    // Next-state and next-entry decode for the occupancy FSM.
    always_comb begin
        state_s  = state_r;
        mem_s[0] = mem_r[0];
        mem_s[1] = mem_r[1];
        case (state_r)
            RD_EMPTY: begin
                if (push_s) begin
                    state_s  = RD_ONE;
                    mem_s[0] = push_data;
                end else begin
                    state_s  = RD_EMPTY;
                end
            end
            RD_ONE: begin
                if (push_s && pop_s) begin
                    // Head leaves while the new entry arrives: it becomes head.
                    state_s  = RD_ONE;
                    mem_s[0] = push_data;
                end else if (push_s) begin
                    state_s  = RD_FULL;
                    mem_s[1] = push_data;
                end else if (pop_s) begin
                    state_s  = RD_EMPTY;
                end else begin
                    state_s  = RD_ONE;
                end
            end
            RD_FULL: begin
                if (pop_s) begin
                    state_s  = RD_ONE;
                    mem_s[0] = mem_r[1];
                end else begin
                    state_s  = RD_FULL;
                end
            end
            default: begin
                state_s = RD_EMPTY;
            end
        endcase
    end

    // State and entry registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= RD_EMPTY;
            mem_r[0] <= {W{1'b0}};
            mem_r[1] <= {W{1'b0}};
        end else begin
            state_r  <= state_s;
            mem_r[0] <= mem_s[0];
            mem_r[1] <= mem_s[1];
        end
    end

endmodule

// File: rtl/register_reader.sv
// register_reader
// Back-pressured, one-cycle-latency read port for a register bank.
// The addressed register is snapshotted into a 2-entry response buffer on
// request accept; out-of-range addresses return data 0 with the error flag.
//   clk      : sole clock
//   reset_n  : asynchronous active-low reset
//   regs_in  : flattened register outputs, register i at [i*N +: N]
//   bus      : register_reader_if.slave request/response handshakes
// Optional feature macro: REGISTER_READER_PARITY_EN adds bus.rsp_parity,
// the even parity of the head entry's data, stored per entry.
module register_reader
    import register_pkg::*;
#(
    parameter int N     = 3,
    parameter int COUNT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [COUNT*N-1:0] regs_in,
    register_reader_if.slave bus
);

    localparam int ADDR_W   = $clog2(COUNT);
    localparam int SLOTS    = 2 ** ADDR_W;
`ifdef REGISTER_READER_PARITY_EN
    localparam int ENTRY_W  = N + 2;
`else
    localparam int ENTRY_W  = N + 1;
`endif

    function automatic logic calc_parity(input logic [N-1:0] d);
        return ^d;
    endfunction

    logic [N-1:0]       slot_s [SLOTS];
    logic [N-1:0]       sel_data_s;
    logic               addr_err_s;
    logic [ENTRY_W-1:0] push_entry_s;
    logic [ENTRY_W-1:0] head_s;

    // Every address decodes to a slot; slots beyond COUNT read as zero,
    // which gives the error entry its zero data without a separate mux.
    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        if (i < COUNT) begin : g_reg
            assign slot_s[i] = regs_in[i*N +: N];
        end else begin : g_pad
            assign slot_s[i] = {N{1'b0}};
        end
    end

    assign sel_data_s = slot_s[bus.req_addr];
    assign addr_err_s = ({1'b0, bus.req_addr} >= (ADDR_W+1)'(COUNT));

`ifdef REGISTER_READER_PARITY_EN
    assign push_entry_s   = {calc_parity(sel_data_s), addr_err_s, sel_data_s};
    assign bus.rsp_parity = head_s[N+1];
`else
    assign push_entry_s   = {addr_err_s, sel_data_s};
`endif

    assign bus.rsp_data  = head_s[N-1:0];
    assign bus.rsp_error = head_s[N];

    register_reader_buffer #(
        .W (ENTRY_W)
    ) u_buffer (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_valid (bus.req_valid),
        .push_data  (push_entry_s),
        .push_ready (bus.req_ready),
        .pop_valid  (bus.rsp_valid),
        .pop_data   (head_s),
        .pop_ready  (bus.rsp_ready)
    );

endmodule

// File: tb/tb_register_reader.sv
// tb_register_reader
// Directed self-checking bench for register_reader: a COUNT=4 instance for
// the main behaviour and a COUNT=3 instance for out-of-range reads.
module tb_register_reader;

    logic        clk;
    logic        reset_n;
    logic [11:0] regs_in;
    logic [8:0]  regs3_in;
    int          pass_cnt;
    int          total_cnt;

    register_reader_if #(.N(3), .COUNT(4)) bus  ();
    register_reader_if #(.N(3), .COUNT(3)) bus3 ();

    register_reader #(.N(3), .COUNT(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .regs_in (regs_in),
        .bus     (bus)
    );

    register_reader #(.N(3), .COUNT(3)) dut3 (
        .clk     (clk),
        .reset_n (reset_n),
        .regs_in (regs3_in),
        .bus     (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_regs(input logic [2:0] r0, input logic [2:0] r1,
                            input logic [2:0] r2, input logic [2:0] r3);
        regs_in = {r3, r2, r1, r0};
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        regs_in        = 12'($urandom());
        bus.req_valid  = 1'b1;
        bus.req_addr   = 2'($urandom());
        bus.rsp_ready  = 1'($urandom());
        repeat (3) step();
        total_cnt++;
        if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %0b expected 0", bus.rsp_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.req_ready !== 1'b1) $display("FAIL reset_req_ready: got %0b expected 1", bus.req_ready);
        else pass_cnt++;
        total_cnt++;
        if (bus.rsp_data !== 3'd0) $display("FAIL reset_rsp_data: got %0d expected 0", bus.rsp_data);
        else pass_cnt++;
        total_cnt++;
        if (bus.rsp_error !== 1'b0) $display("FAIL reset_rsp_error: got %0b expected 0", bus.rsp_error);
        else pass_cnt++;
        // Release and read register 2 on the first edge after deassertion.
        reset_n       = 1'b1;
        bus.rsp_ready = 1'b0;
        set_regs(3'd0, 3'd0, 3'd5, 3'd0);
        bus.req_valid = 1'b1;
        bus.req_addr  = 2'd2;
        step();
        total_cnt++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 3'd5 || bus.rsp_error !== 1'b0)
            $display("FAIL first_read: got valid=%0b data=%0d err=%0b expected valid=1 data=5 err=0",
                     bus.rsp_valid, bus.rsp_data, bus.rsp_error);
        else pass_cnt++;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        step();
        total_cnt++;
        if (bus.rsp_valid !== 1'b0) $display("FAIL first_pop: got valid=%0b expected 0", bus.rsp_valid);
        else pass_cnt++;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_streaming();
        logic [2:0] exp_data;
        set_regs(3'd1, 3'd2, 3'd3, 3'd4);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            step();
            exp_data = 3'(i + 1);
            total_cnt++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_data || bus.req_ready !== 1'b1)
                $display("FAIL stream_%0d: got valid=%0b data=%0d req_ready=%0b expected valid=1 data=%0d req_ready=1",
                         i, bus.rsp_valid, bus.rsp_data, bus.req_ready, exp_data);
            else pass_cnt++;
            if (i < 3) bus.req_addr = 2'(i + 1);
            else bus.req_valid = 1'b0;
        end
        step();
        total_cnt++;
        if (bus.rsp_valid !== 1'b0) $display("FAIL stream_drain: got valid=%0b expected 0", bus.rsp_valid);
        else pass_cnt++;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        set_regs(3'd7, 3'd5, 3'd0, 3'd2);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 2'd1;
        step();
        total_cnt++;
        if (bus.req_ready !== 1'b1 || bus.rsp_data !== 3'd5)
            $display("FAIL bp_first: got req_ready=%0b data=%0d expected req_ready=1 data=5",
                     bus.req_ready, bus.rsp_data);
        else pass_cnt++;
        bus.req_addr = 2'd3;
        step();
        total_cnt++;
        if (bus.req_ready !== 1'b0 || bus.rsp_data !== 3'd5)
            $display("FAIL bp_full: got req_ready=%0b data=%0d expected req_ready=0 data=5",
                     bus.req_ready, bus.rsp_data);
        else pass_cnt++;
        // Third request must be held off while full.
        bus.req_addr = 2'd0;
        step();
        total_cnt++;
        if (bus.req_ready !== 1'b0 || bus.rsp_data !== 3'd5)
            $display("FAIL bp_hold: got req_ready=%0b data=%0d expected req_ready=0 data=5",
                     bus.req_ready, bus.rsp_data);
        else pass_cnt++;
        bus.rsp_ready = 1'b1;
        step();
        total_cnt++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b1 || bus.rsp_data !== 3'd2)
            $display("FAIL bp_second: got req_ready=%0b valid=%0b data=%0d expected req_ready=1 valid=1 data=2",
                     bus.req_ready, bus.rsp_valid, bus.rsp_data);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 3'd7)
            $display("FAIL bp_third: got valid=%0b data=%0d expected valid=1 data=7",
                     bus.rsp_valid, bus.rsp_data);
        else pass_cnt++;
        bus.req_valid = 1'b0;
        step();
        total_cnt++;
        if (bus.rsp_valid !== 1'b0) $display("FAIL bp_drain: got valid=%0b expected 0", bus.rsp_valid);
        else pass_cnt++;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_snapshot();
        set_regs(3'd6, 3'd0, 3'd0, 3'd0);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 2'd0;
        step();
        bus.req_valid = 1'b0;
        set_regs(3'd1, 3'd0, 3'd0, 3'd0);
        step();
        total_cnt++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 3'd6)
            $display("FAIL snapshot: got valid=%0b data=%0d expected valid=1 data=6",
                     bus.rsp_valid, bus.rsp_data);
        else pass_cnt++;
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_out_of_range();
        regs3_in       = {3'd7, 3'd6, 3'd5};
        bus3.rsp_ready = 1'b0;
        bus3.req_valid = 1'b1;
        bus3.req_addr  = 2'd3;
        step();
        total_cnt++;
        if (bus3.rsp_valid !== 1'b1 || bus3.rsp_data !== 3'd0 || bus3.rsp_error !== 1'b1)
            $display("FAIL oor_read: got valid=%0b data=%0d err=%0b expected valid=1 data=0 err=1",
                     bus3.rsp_valid, bus3.rsp_data, bus3.rsp_error);
        else pass_cnt++;
`ifdef REGISTER_READER_PARITY_EN
        total_cnt++;
        if (bus3.rsp_parity !== 1'b0) $display("FAIL oor_parity: got %0b expected 0", bus3.rsp_parity);
        else pass_cnt++;
`endif
        bus3.rsp_ready = 1'b1;
        bus3.req_addr  = 2'd2;
        step();
        total_cnt++;
        if (bus3.rsp_valid !== 1'b1 || bus3.rsp_data !== 3'd7 || bus3.rsp_error !== 1'b0)
            $display("FAIL oor_last_valid: got valid=%0b data=%0d err=%0b expected valid=1 data=7 err=0",
                     bus3.rsp_valid, bus3.rsp_data, bus3.rsp_error);
        else pass_cnt++;
        bus3.req_valid = 1'b0;
        step();
        bus3.rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        set_regs(3'd0, 3'b011, 3'b111, 3'd0);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 2'd1;
        step();
        total_cnt++;
        if (bus.rsp_data !== 3'b011) $display("FAIL mid_head3: got %0d expected 3", bus.rsp_data);
        else pass_cnt++;
`ifdef REGISTER_READER_PARITY_EN
        total_cnt++;
        if (bus.rsp_parity !== 1'b0) $display("FAIL parity_011: got %0b expected 0", bus.rsp_parity);
        else pass_cnt++;
`endif
        bus.req_addr = 2'd2;
        step();
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        step();
        total_cnt++;
        if (bus.rsp_data !== 3'b111) $display("FAIL mid_head7: got %0d expected 7", bus.rsp_data);
        else pass_cnt++;
`ifdef REGISTER_READER_PARITY_EN
        total_cnt++;
        if (bus.rsp_parity !== 1'b1) $display("FAIL parity_111: got %0b expected 1", bus.rsp_parity);
        else pass_cnt++;
`endif
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 2'd1;
        step();
        total_cnt++;
        if (bus.req_ready !== 1'b0) $display("FAIL mid_full: got req_ready=%0b expected 0", bus.req_ready);
        else pass_cnt++;
        // Assert reset between edges: buffer must clear without a clock.
        #2;
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.rsp_data !== 3'd0)
            $display("FAIL mid_reset_now: got valid=%0b req_ready=%0b data=%0d expected valid=0 req_ready=1 data=0",
                     bus.rsp_valid, bus.req_ready, bus.rsp_data);
        else pass_cnt++;
        repeat (2) step();
        total_cnt++;
        if (bus.rsp_valid !== 1'b0) $display("FAIL mid_reset_hold: got valid=%0b expected 0", bus.rsp_valid);
        else pass_cnt++;
        reset_n       = 1'b1;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        step();
        total_cnt++;
        if (bus.rsp_valid !== 1'b0) $display("FAIL mid_no_stale: got valid=%0b expected 0", bus.rsp_valid);
        else pass_cnt++;
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        pass_cnt       = 0;
        total_cnt      = 0;
        reset_n        = 1'b0;
        regs_in        = 12'd0;
        regs3_in       = 9'd0;
        bus.req_valid  = 1'b0;
        bus.req_addr   = 2'd0;
        bus.rsp_ready  = 1'b0;
        bus3.req_valid = 1'b0;
        bus3.req_addr  = 2'd0;
        bus3.rsp_ready = 1'b0;
        #1;
        test_reset();
        test_streaming();
        test_back_to_back();
        test_snapshot();
        test_out_of_range();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
